// File: rtl/lfsr_word_arbiter.sv
// lfsr_word_arbiter: shares one serial LFSR among N_REQ requesters.
// A grant is served by WORD_W advance cycles that collect one bit each. The collected
// word is returned with a one-cycle gnt pulse. Reseeds are queued and run only between words.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (reseeds automatically on an all-zero LFSR state).
module lfsr_word_arbiter #(
  parameter int unsigned        N_REQ        = 4,
  parameter int unsigned        WORD_W       = 8,
  parameter int unsigned        STATE_W      = 5,
  parameter logic [STATE_W-1:0] SEED_DEFAULT = STATE_W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   gnt,
  output logic [WORD_W-1:0]  word,
  input  logic               reseed_req,
  input  logic [STATE_W-1:0] seed_in,
  output logic               busy,
  output logic               lfsr_advance,
  output logic               lfsr_reinit,
  output logic [STATE_W-1:0] lfsr_seed,
  input  logic               lfsr_out,
  input  logic [STATE_W-1:0] lfsr_state
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESEED = 2'd1,
    GEN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   rr, rr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [STATE_W-1:0] seed_hold, seed_hold_nxt;
  logic               reseed_pend, reseed_pend_nxt;
  logic [STATE_W-1:0] seed_nxt;
  logic [WORD_W-1:0]  word_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic               busy_nxt, advance_nxt, reinit_nxt;
  logic [IDX_W-1:0]   pick;
  logic               found;

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lockup_seen, lockup_seen_nxt;
  logic unused_lockup;
  assign unused_lockup = lockup_seen;
`else
  logic unused_state;
  assign unused_state = ^lfsr_state;
`endif

  // Round-robin search: first asserted request at or after the rr pointer
  always_comb begin
    pick  = rr;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[(32'(rr) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = IDX_W'((32'(rr) + i) % N_REQ);
      end
    end
  end

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    rr_nxt          = rr;
    cnt_nxt         = cnt;
    seed_hold_nxt   = seed_hold;
    reseed_pend_nxt = reseed_pend;
    seed_nxt        = lfsr_seed;
    word_nxt        = word;
`ifdef LFSR_LOCKUP_RECOVER_EN
    lockup_seen_nxt = lockup_seen;
`endif
    case (state)
      IDLE: begin
        if (reseed_pend) begin
          state_nxt       = RESEED;
          seed_nxt        = seed_hold;
          reseed_pend_nxt = 1'b0;
        end
`ifdef LFSR_LOCKUP_RECOVER_EN
        else if (lfsr_state == '0) begin
          // Stuck LFSR: reload whatever seed is already presented
          state_nxt       = RESEED;
          lockup_seen_nxt = 1'b1;
        end
`endif
        else if (found) begin
          state_nxt = GEN;
          owner_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      RESEED: state_nxt = IDLE;
      GEN: begin
        word_nxt[cnt] = lfsr_out;
        if (cnt == CNT_W'(WORD_W - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        rr_nxt    = (32'(owner) == N_REQ - 1) ? '0 : owner + IDX_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    // A new reseed request always pends, overwriting any earlier one
    if (reseed_req) begin
      reseed_pend_nxt = 1'b1;
      seed_hold_nxt   = seed_in;
    end
    gnt_nxt     = (state_nxt == DONE) ? (N_REQ'(1) << owner_nxt) : '0;
    busy_nxt    = (state_nxt != IDLE);
    advance_nxt = (state_nxt == GEN);
    reinit_nxt  = (state_nxt == RESEED);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= '0;
      rr           <= '0;
      cnt          <= '0;
      seed_hold    <= SEED_DEFAULT;
      reseed_pend  <= 1'b0;
      lfsr_seed    <= SEED_DEFAULT;
      word         <= '0;
      gnt          <= '0;
      busy         <= 1'b0;
      lfsr_advance <= 1'b0;
      lfsr_reinit  <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_seen  <= 1'b0;
`endif
    end else begin
      owner        <= owner_nxt;
      rr           <= rr_nxt;
      cnt          <= cnt_nxt;
      seed_hold    <= seed_hold_nxt;
      reseed_pend  <= reseed_pend_nxt;
      lfsr_seed    <= seed_nxt;
      word         <= word_nxt;
      gnt          <= gnt_nxt;
      busy         <= busy_nxt;
      lfsr_advance <= advance_nxt;
      lfsr_reinit  <= reinit_nxt;
`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_seen  <= lockup_seen_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// Testbench for lfsr_word_arbiter: directed scenarios, then randomized traffic.
// A cycle-timeline model predicts every output on every cycle.
module tb_lfsr_word_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXC = 4096;
  localparam logic [4:0] SEED_DEF = 5'h01;

  logic       clk = 1'b0;
  logic       rst, reseed_req, lfsr_out;
  logic [3:0] req;
  logic [4:0] seed_in, lfsr_state;
  logic [3:0] gnt;
  logic [7:0] word;
  logic       busy, lfsr_advance, lfsr_reinit;
  logic [4:0] lfsr_seed;

  lfsr_word_arbiter #(.N_REQ(N), .WORD_W(W), .STATE_W(5), .SEED_DEFAULT(SEED_DEF)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .word(word),
    .reseed_req(reseed_req), .seed_in(seed_in), .busy(busy),
    .lfsr_advance(lfsr_advance), .lfsr_reinit(lfsr_reinit), .lfsr_seed(lfsr_seed),
    .lfsr_out(lfsr_out), .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  // Timeline model: expected outputs per absolute cycle number
  bit         e_adv[MAXC], e_rei[MAXC], e_busy[MAXC], e_gv[MAXC], e_rst[MAXC];
  int         e_own[MAXC];
  bit         hist[MAXC];
  int         cyc, next_free, rr_m, seed_chg_cyc;
  bit         mvalid, pend_m, hold_req;
  logic [4:0] hold_m, seed_m, seed_chg_val;
  logic [3:0] gnt_m;
  int         n_checks, n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Compare DUT outputs of the current cycle with the model
  task automatic check_cycle();
    logic [3:0] exp_g;
    logic [7:0] w;
    gnt_m = '0;
    if (!mvalid) return;
    if (seed_chg_cyc == cyc) seed_m = seed_chg_val;
    exp_g = e_gv[cyc] ? 4'(1 << e_own[cyc]) : 4'h0;
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("advance", 32'(lfsr_advance), 32'(e_adv[cyc]));
    chk("reinit", 32'(lfsr_reinit), 32'(e_rei[cyc]));
    chk("busy", 32'(busy), 32'(e_busy[cyc]));
    chk("seed", 32'(lfsr_seed), 32'(seed_m));
    if (e_gv[cyc]) begin
      for (int i = 0; i < W; i++) w[i] = hist[cyc - W + i];
      chk("word", 32'(word), 32'(w));
    end
    if (e_rst[cyc]) chk("word_reset", 32'(word), 32'h0);
    gnt_m = exp_g;
    if (!hold_req) req = req & ~gnt_m;
  endtask

  // Apply this cycle's inputs to the model
  task automatic model_step(input int c);
    int o;
    if (rst) begin
      for (int k = c + 1; k <= c + W + 3; k++) begin
        e_adv[k] = 0; e_rei[k] = 0; e_busy[k] = 0; e_gv[k] = 0; e_rst[k] = 0;
      end
      e_rst[c + 1] = 1;
      seed_chg_cyc = c + 1;
      seed_chg_val = SEED_DEF;
      pend_m = 0; rr_m = 0; next_free = c + 1; mvalid = 1;
      return;
    end
    if (!mvalid) return;
    hist[c] = lfsr_out;
    if (c == next_free) begin
      if (pend_m) begin
        e_rei[c + 1] = 1; e_busy[c + 1] = 1;
        seed_chg_cyc = c + 1; seed_chg_val = hold_m;
        pend_m = 0; next_free = c + 2;
      end
`ifdef LFSR_LOCKUP_RECOVER_EN
      else if (lfsr_state == 5'h0) begin
        e_rei[c + 1] = 1; e_busy[c + 1] = 1; next_free = c + 2;
      end
`endif
      else if (req != 4'h0) begin
        o = -1;
        for (int k = 0; k < N; k++)
          if (o < 0 && req[(rr_m + k) % N]) o = (rr_m + k) % N;
        for (int k = 1; k <= W; k++) begin e_adv[c + k] = 1; e_busy[c + k] = 1; end
        e_busy[c + W + 1] = 1; e_gv[c + W + 1] = 1; e_own[c + W + 1] = o;
        rr_m = (o + 1) % N;
        next_free = c + W + 2;
      end else begin
        next_free = c + 1;
      end
    end
    if (reseed_req) begin pend_m = 1; hold_m = seed_in; end
  endtask

  task automatic advance();
    model_step(cyc);
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic do_reset();
    rst = 1; req = '0; reseed_req = 0; lfsr_out = 0; lfsr_state = 5'h1f; hold_req = 0;
    advance();
    rst = 0;
  endtask

  initial begin
    int base;
    bit pat[8];
    logic [3:0] ord[5];
    logic [3:0] gor;
    n_checks = 0; n_pass = 0; cyc = 0; mvalid = 0; hold_req = 0;
    rst = 1; req = '0; reseed_req = 0; seed_in = '0; lfsr_out = 0; lfsr_state = 5'h1f;
    @(negedge clk);
    check_cycle();

    // Constant-one LFSR, single requester: grant at relative cycle 9 with 8'hFF
    do_reset(); base = cyc;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_seed", 32'(lfsr_seed), 32'(SEED_DEF));
    req = 4'b0001; lfsr_out = 1;
    while (cyc < base + 9) advance();
    chk("lit_gnt_ff", 32'(gnt), 32'h1);
    chk("lit_word_ff", 32'(word), 32'hff);

    // Bit pattern 1,0,1,1,0,0,0,1 -> 8'h8D
    do_reset(); base = cyc;
    pat = '{1, 0, 1, 1, 0, 0, 0, 1};
    req = 4'b0001;
    while (cyc < base + 9) begin
      if (cyc >= base + 1) lfsr_out = pat[cyc - base - 1];
      advance();
    end
    chk("lit_word_8d", 32'(word), 32'h8d);

    // All requesters held: round-robin every 10 cycles
    do_reset(); base = cyc;
    ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    hold_req = 1; req = 4'hf;
    for (int g = 0; g < 5; g++) begin
      while (cyc < base + 9 + 10 * g) begin lfsr_out = 1'($urandom); advance(); end
      chk("lit_rr_order", 32'(gnt), 32'(ord[g]));
    end
    hold_req = 0; req = '0;

    // Reseed during GEN: word completes, RESEED with 5'h13, then pending request
    do_reset(); base = cyc;
    req = 4'b0001;
    while (cyc < base + 21) begin
      reseed_req = (cyc == base + 3);
      if (cyc == base + 3) seed_in = 5'h13;
      if (cyc == base + 5) req = req | 4'b0010;
      lfsr_out = 1'($urandom);
      advance();
      if (cyc == base + 9)  chk("lit_gnt_before_reseed", 32'(gnt), 32'h1);
      if (cyc == base + 11) begin
        chk("lit_reseed_reinit", 32'(lfsr_reinit), 32'h1);
        chk("lit_reseed_seed", 32'(lfsr_seed), 32'h13);
      end
    end
    chk("lit_gnt_after_reseed", 32'(gnt), 32'h2);

    // Reset on GEN cycle 4: all outputs reset, no grant afterwards
    do_reset(); base = cyc;
    req = 4'b0001;
    while (cyc < base + 5) advance();
    rst = 1;
    advance();
    rst = 0; req = '0;
    chk("lit_midrst_busy", 32'(busy), 32'h0);
    chk("lit_midrst_adv", 32'(lfsr_advance), 32'h0);
    chk("lit_midrst_gnt", 32'(gnt), 32'h0);
    gor = '0;
    for (int k = 0; k < 12; k++) begin advance(); gor = gor | gnt; end
    chk("lit_midrst_no_gnt", 32'(gor), 32'h0);

    // All-zero LFSR state in IDLE
    do_reset(); base = cyc;
    lfsr_state = 5'h0; req = 4'b0100;
    advance();
    lfsr_state = 5'h1f;
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("lit_lockup_reinit", 32'(lfsr_reinit), 32'h1);
    chk("lit_lockup_seed", 32'(lfsr_seed), 32'h01);
    while (cyc < base + 11) advance();
    chk("lit_lockup_gnt", 32'(gnt), 32'h4);
`else
    chk("lit_nolockup_adv", 32'(lfsr_advance), 32'h1);
    while (cyc < base + 9) advance();
    chk("lit_nolockup_gnt", 32'(gnt), 32'h4);
`endif

    // Randomized traffic
    req = '0;
    for (int k = 0; k < 2000; k++) begin
      rst        = ($urandom_range(299) == 0);
      reseed_req = ($urandom_range(15) == 0);
      seed_in    = 5'($urandom);
      lfsr_out   = 1'($urandom);
      lfsr_state = ($urandom_range(7) == 0) ? 5'h0 : 5'($urandom);
      for (int b = 0; b < N; b++)
        if (!req[b] && $urandom_range(3) == 0) req[b] = 1'b1;
      if ($urandom_range(63) == 0) req = req & 4'($urandom);
      advance();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
